sha2_sched_stream: RTL and testbench

Parametrised SHA-2 message-schedule generator. It accepts one 16-word message block over a valid/ready handshake and streams the expanded schedule words W0..W(ROUNDS-1), one per handshake, to the compression round datapath. It is the successor of the fixed 32-bit free-running W generator. It adds SHA-512 word width, round counting, last-word flagging, downstream back-pressure and bubble-free back-to-back block loading.

---
 rtl/sha2_sched_stream.sv | 107 ++++++++++
 tb/tb_sha2_sched_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_sched_stream.sv
// SHA-2 message-schedule generator: loads a 16-word block and streams W0..W(ROUNDS-1)
// over a valid/ready handshake, with back-to-back block reload on the final word.
module sha2_sched_stream #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*WORD_W-1:0]   m_data,
  input  logic                   m_valid,
  output logic                   m_ready,
  output logic [WORD_W-1:0]      w_data,
  output logic [6:0]             w_idx,
  output logic                   w_last,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic                   busy
);

  if (WORD_W != 32 && WORD_W != 64) begin : gen_bad_width
    $error("sha2_sched_stream: WORD_W must be 32 or 64");
  end

  localparam int unsigned ROUNDS  = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0]  LastIdx = 7'(ROUNDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [WORD_W-1:0] window_q [16];
  logic [WORD_W-1:0] window_d [16];
  logic [WORD_W-1:0] w_next;
  logic              at_last;
  logic              load_en;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign w_next  = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];
  assign at_last = (idx_q == LastIdx);

  assign w_valid = (state_q == StRun);
  assign busy    = w_valid;
  assign w_data  = window_q[0];
  assign w_idx   = idx_q;
  assign w_last  = w_valid && at_last;
  // Depends on w_ready only, never on m_valid.
  assign m_ready = (state_q == StIdle) || (w_valid && at_last && w_ready);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    window_d = window_q;
    load_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (m_valid) begin
          load_en = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (w_ready) begin
          if (!at_last) begin
            for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
            window_d[15] = w_next;
            idx_d        = idx_q + 7'd1;
          end else if (m_valid) begin
            load_en = 1'b1;
          end else begin
            state_d = StIdle;
            idx_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_en) begin
      for (int i = 0; i < 16; i++) window_d[i] = m_data[(15-i)*WORD_W +: WORD_W];
      idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      window_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      window_q <= window_d;
    end
  end

endmodule

// File: tb/tb_sha2_sched_stream.sv
// Self-checking bench for sha2_sched_stream: 32- and 64-bit instances against a
// recurrence-based schedule model, with random blocks and random back-pressure.
module tb_sha2_sched_stream;

  logic          clk = 1'b0;
  logic          rst;

  logic [511:0]  m_data32;
  logic          m_valid32, m_ready32;
  logic [31:0]   w_data32;
  logic [6:0]    w_idx32;
  logic          w_last32, w_valid32, w_ready32, busy32;

  logic [1023:0] m_data64;
  logic          m_valid64, m_ready64;
  logic [63:0]   w_data64;
  logic [6:0]    w_idx64;
  logic          w_last64, w_valid64, w_ready64, busy64;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mblk  [16];
  logic [63:0] mw    [80];
  logic [63:0] got_w [80];

  logic [63:0] o_data;
  logic [6:0]  o_idx;
  logic        o_last, o_valid, o_busy, o_mready;

  sha2_sched_stream #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .m_data(m_data32), .m_valid(m_valid32), .m_ready(m_ready32),
    .w_data(w_data32), .w_idx(w_idx32), .w_last(w_last32), .w_valid(w_valid32),
    .w_ready(w_ready32), .busy(busy32)
  );

  sha2_sched_stream #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .m_data(m_data64), .m_valid(m_valid64), .m_ready(m_ready64),
    .w_data(w_data64), .w_idx(w_idx64), .w_last(w_last64), .w_valid(w_valid64),
    .w_ready(w_ready64), .busy(busy64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain SHA-2 schedule recurrence over a word array.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
    if (ww == 64) return (x >> n) | (x << (64 - n));
    return {32'b0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int ww);
    if (ww == 64) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int ww);
    if (ww == 64) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
  endfunction

  task automatic build_model(input int ww);
    int r;
    r = (ww == 64) ? 80 : 64;
    for (int t = 0; t < 16; t++) mw[t] = mblk[t];
    for (int t = 16; t < r; t++) begin
      mw[t] = s1(mw[t-2], ww) + mw[t-7] + s0(mw[t-15], ww) + mw[t-16];
      if (ww == 32) mw[t][63:32] = 32'b0;
    end
  endtask

  task automatic abc_block(input int ww);
    for (int i = 0; i < 16; i++) mblk[i] = 64'b0;
    mblk[0]  = (ww == 64) ? 64'h6162_6380_0000_0000 : 64'h6162_6380;
    mblk[15] = 64'h18;
  endtask

  task automatic rand_block(input int ww);
    for (int i = 0; i < 16; i++)
      mblk[i] = (ww == 64) ? {$urandom, $urandom} : {32'b0, $urandom};
  endtask

  task automatic pack(input int ww);
    for (int i = 0; i < 16; i++) begin
      if (ww == 64) m_data64[(15-i)*64 +: 64] = mblk[i];
      else          m_data32[(15-i)*32 +: 32] = mblk[i][31:0];
    end
  endtask

  task automatic sample(input int ww);
    if (ww == 64) begin
      o_data = w_data64; o_idx = w_idx64; o_last = w_last64;
      o_valid = w_valid64; o_busy = busy64; o_mready = m_ready64;
    end else begin
      o_data = {32'b0, w_data32}; o_idx = w_idx32; o_last = w_last32;
      o_valid = w_valid32; o_busy = busy32; o_mready = m_ready32;
    end
  endtask

  task automatic set_ready(input int ww, input logic r);
    if (ww == 64) w_ready64 = r; else w_ready32 = r;
  endtask

  task automatic set_mvalid(input int ww, input logic v);
    if (ww == 64) m_valid64 = v; else m_valid32 = v;
  endtask

  task automatic load(input int ww);
    @(negedge clk);
    pack(ww);
    set_mvalid(ww, 1'b1);
    set_ready(ww, 1'b1);
    #1 sample(ww);
    chk("load_m_ready", 64'(o_mready), 64'd1);
    @(posedge clk);
    #1 set_mvalid(ww, 1'b0);
  endtask

  // Accepts nstop words; rmode 0 = always ready, 1 = random back-pressure.
  task automatic consume(input int ww, input int rmode, input int nstop);
    int          rounds, got;
    logic        r, stall;
    logic [63:0] pd;
    logic [6:0]  pi;
    logic        pl;
    rounds = (ww == 64) ? 80 : 64;
    got    = 0;
    stall  = 1'b0;
    pd = '0; pi = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 2000 && got < nstop; cyc++) begin
      @(negedge clk);
      r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      set_ready(ww, r);
      #1 sample(ww);
      chk("w_valid_run", 64'(o_valid), 64'd1);
      chk("busy_run", 64'(o_busy), 64'd1);
      chk("m_ready_run", 64'(o_mready), 64'(r && got == rounds - 1));
      if (stall) begin
        chk("stall_data", o_data, pd);
        chk("stall_idx", 64'(o_idx), 64'(pi));
        chk("stall_last", 64'(o_last), 64'(pl));
      end
      if (r) begin
        chk("w_data", o_data, mw[got]);
        chk("w_idx", 64'(o_idx), 64'(got));
        chk("w_last", 64'(o_last), 64'(got == rounds - 1));
        got_w[got] = o_data;
        got++;
      end
      stall = !r;
      pd = o_data; pi = o_idx; pl = o_last;
    end
    chk("word_count", 64'(got), 64'(nstop));
  endtask

  task automatic idle_chk(input int ww);
    @(negedge clk);
    #1 sample(ww);
    chk("idle_w_valid", 64'(o_valid), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_w_last", 64'(o_last), 64'd0);
    chk("idle_m_ready", 64'(o_mready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    w_ready32 = 1'b1; w_ready64 = 1'b1;
    abc_block(32); pack(32);
    abc_block(64); pack(64);
    m_valid32 = 1'b1; m_valid64 = 1'b1;

    // Reset held with a block offered: nothing loads.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 sample(32);
      chk("rst_w_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_w_idx", 64'(o_idx), 64'd0);
      sample(64);
      chk("rst_w_valid64", 64'(o_valid), 64'd0);
    end
    rst = 1'b0;
    m_valid32 = 1'b0; m_valid64 = 1'b0;
    @(negedge clk);
    #1 sample(32);
    chk("post_rst_m_ready", 64'(o_mready), 64'd1);
    chk("post_rst_w_valid", 64'(o_valid), 64'd0);
    chk("post_rst_w_data", o_data, 64'd0);

    // SHA-256 "abc", always ready.
    abc_block(32); build_model(32);
    load(32);
    consume(32, 0, 64);
    chk("abc_w0", got_w[0], 64'h6162_6380);
    chk("abc_w15", got_w[15], 64'h18);
    chk("abc_w16", got_w[16], 64'h6162_6380);
    chk("abc_w17", got_w[17], 64'h000F_0000);
    idle_chk(32);

    // Same block under random back-pressure.
    load(32);
    consume(32, 1, 64);
    idle_chk(32);

    // Back-to-back random blocks, m_valid held high across the boundary.
    rand_block(32); build_model(32);
    load(32);
    rand_block(32); pack(32);
    m_valid32 = 1'b1;
    consume(32, 1, 64);
    @(posedge clk);
    #1 m_valid32 = 1'b0;
    build_model(32);
    consume(32, 0, 64);
    idle_chk(32);

    // Reset mid-run at w_idx=20, then reload "abc".
    abc_block(32); build_model(32);
    load(32);
    consume(32, 1, 20);
    @(negedge clk);
    w_ready32 = 1'b1;
    rst = 1'b1;
    #1 sample(32);
    chk("pre_rst_idx", 64'(o_idx), 64'd20);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 sample(32);
    chk("midrst_w_valid", 64'(o_valid), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_w_idx", 64'(o_idx), 64'd0);
    chk("midrst_w_data", o_data, 64'd0);
    load(32);
    consume(32, 1, 64);
    idle_chk(32);

    // SHA-512 "abc", then a random block with back-pressure.
    abc_block(64); build_model(64);
    load(64);
    consume(64, 0, 80);
    chk("abc512_w16", got_w[16], 64'h6162_6380_0000_0000);
    chk("abc512_w17", got_w[17], 64'h0003_0000_0000_00C0);
    idle_chk(64);
    rand_block(64); build_model(64);
    load(64);
    consume(64, 1, 80);
    idle_chk(64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
